ram_rd_slave: RTL and testbench

RAM_RD_SLAVE -- requirements
Module: ram_rd_slave

---
 rtl/ram_rd_slave_pkg.sv | 39 +++
 rtl/ram_rd_slave_if.sv | 36 +++
 rtl/ram_rd_slave_fifo.sv | 56 +++++
 rtl/ram_rd_slave.sv | 148 ++++++++++++++
 tb/tb_ram_rd_slave.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_rd_slave_pkg.sv
// Shared AXI read-side types, field widths and response codes for the SRAM read slave.
package ram_rd_slave_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 4;
  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;
  localparam int BEAT_W  = DATA_W + RESP_W + 1 + ID_W;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [BURST_W-1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ram_rd_slave_if.sv
// AXI4 read-address and read-data channels; "in" is the slave side, "out" the master side.
interface axi_if;
  import ram_rd_slave_pkg::*;

  logic               arvalid;
  logic               arready;
  logic [ADDR_W-1:0]  araddr;
  logic [ID_W-1:0]    arid;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               rvalid;
  logic               rready;
  logic [DATA_W-1:0]  rdata;
  logic [RESP_W-1:0]  rresp;
  logic               rlast;
  logic [ID_W-1:0]    rid;

  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/ram_rd_slave_fifo.sv
// Two-entry fall-through beat FIFO: an arriving beat is visible at the head in the same cycle.
module rd_beat_fifo
  import ram_rd_slave_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output logic [1:0] count,
  output logic       valid,
  output beat_t      head
);

  beat_t      mem_r [2];
  logic       rd_r;
  logic       wr_r;
  logic [1:0] cnt_r;
  logic       wr_en_s;
  logic       rd_adv_s;

  // A beat popped straight through an empty FIFO never occupies storage.
  always_comb begin
    wr_en_s  = push && !((cnt_r == 2'd0) && pop);
    rd_adv_s = pop && (cnt_r != 2'd0);
    valid    = (cnt_r != 2'd0) || push;
    if (cnt_r != 2'd0) begin
      head = mem_r[rd_r];
    end else if (push) begin
      head = push_beat;
    end else begin
      head = {BEAT_W{1'b0}};
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_r  <= 1'b0;
      wr_r  <= 1'b0;
      cnt_r <= 2'd0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_r] <= push_beat;
        wr_r        <= ~wr_r;
      end
      if (rd_adv_s) begin
        rd_r <= ~rd_r;
      end
      cnt_r <= cnt_r + {1'b0, wr_en_s} - {1'b0, rd_adv_s};
    end
  end

  assign count = cnt_r;

endmodule

// File: rtl/ram_rd_slave.sv
// AXI4 read slave in front of a one-cycle-latency SRAM; one burst at a time, up to 1 beat/cycle.
module ram_rd_slave
  import ram_rd_slave_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 32768
) (
  input  logic                         clock,
  input  logic                         reset,
  axi_if.in                            ram_r,
  output logic                         mem_en,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  input  logic [31:0]                  mem_rdata
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(MEM_WORDS) * 32'd4;

  state_e            state_r, state_s;
  logic [31:0]       addr_r, next_addr_s, step_s, wrap_mask_s, offset_s;
  logic [ID_W-1:0]   id_r;
  logic [LEN_W-1:0]  len_r;
  logic [SIZE_W-1:0] size_r;
  burst_e            burst_r;
  logic              burst_err_r, sticky_r;
  logic [8:0]        issued_r, returned_r;
  logic              infl_r, infl_err_r, infl_last_r;
  logic [1:0]        occ_s;
  logic              ar_hs_s, pop_s, issue_s, beat_err_s, head_valid_s;
  beat_t             push_beat_s, head_s;

  // Issue credit keeps FIFO occupancy plus the in-flight SRAM read within two entries.
  always_comb begin
    ar_hs_s     = ram_r.arvalid && (state_r == IDLE);
    pop_s       = head_valid_s && ram_r.rready;
    offset_s    = addr_r - BASE;
    beat_err_s  = burst_err_r || sticky_r || (offset_s >= SPAN_BYTES);
    issue_s     = (state_r == BURST) && (issued_r <= {1'b0, len_r}) &&
                  ((3'(occ_s) + 3'(infl_r)) < (3'd2 + 3'(pop_s)));
    mem_en      = issue_s && !beat_err_s;
    mem_addr    = mem_en ? offset_s[IDX_W+1:2] : {IDX_W{1'b0}};
    step_s      = 32'd1 << size_r;
    wrap_mask_s = (({24'd0, len_r} + 32'd1) << size_r) - 32'd1;
    next_addr_s = addr_r;
    case (burst_r)
      BURST_FIXED: next_addr_s = addr_r;
      BURST_INCR:  next_addr_s = addr_r + step_s;
      BURST_WRAP:  next_addr_s = (addr_r & ~wrap_mask_s) | ((addr_r + step_s) & wrap_mask_s);
      default:     next_addr_s = addr_r;
    endcase
  end

  // Next-state logic: leave BURST only when the final beat is accepted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_s = BURST;
        end else begin
          state_s = IDLE;
        end
      end
      BURST: begin
        if (pop_s && (returned_r == {1'b0, len_r})) begin
          state_s = IDLE;
        end else begin
          state_s = BURST;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Burst context, beat counters and the one-deep SRAM in-flight stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= 32'd0;
      id_r        <= {ID_W{1'b0}};
      len_r       <= 8'd0;
      size_r      <= 3'd0;
      burst_r     <= BURST_FIXED;
      burst_err_r <= 1'b0;
      sticky_r    <= 1'b0;
      issued_r    <= 9'd0;
      returned_r  <= 9'd0;
      infl_r      <= 1'b0;
      infl_err_r  <= 1'b0;
      infl_last_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      infl_r      <= issue_s;
      infl_err_r  <= beat_err_s;
      infl_last_r <= (issued_r == {1'b0, len_r});
      if (ar_hs_s) begin
        addr_r      <= ram_r.araddr;
        id_r        <= ram_r.arid;
        len_r       <= ram_r.arlen;
        size_r      <= ram_r.arsize;
        burst_r     <= burst_e'(ram_r.arburst);
        burst_err_r <= (ram_r.arsize > 3'd2) || (ram_r.arburst == 2'd3) ||
                       ((ram_r.arburst == 2'd2) && !wrap_len_ok(ram_r.arlen));
        sticky_r    <= 1'b0;
        issued_r    <= 9'd0;
        returned_r  <= 9'd0;
      end else begin
        if (issue_s) begin
          issued_r <= issued_r + 9'd1;
          addr_r   <= next_addr_s;
          // Once a burst has walked off the SRAM window it stays errored.
          if (beat_err_s) begin
            sticky_r <= 1'b1;
          end
        end
        if (pop_s) begin
          returned_r <= returned_r + 9'd1;
        end
      end
    end
  end

  always_comb begin
    push_beat_s.data = infl_err_r ? 32'd0 : mem_rdata;
    push_beat_s.resp = infl_err_r ? RESP_SLVERR : RESP_OKAY;
    push_beat_s.last = infl_last_r;
    push_beat_s.id   = id_r;
  end

  rd_beat_fifo u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (infl_r),
    .push_beat (push_beat_s),
    .pop       (pop_s),
    .count     (occ_s),
    .valid     (head_valid_s),
    .head      (head_s)
  );

  assign ram_r.arready = (state_r == IDLE);
  assign ram_r.rvalid  = head_valid_s;
  assign ram_r.rdata   = head_s.data;
  assign ram_r.rresp   = head_s.resp;
  assign ram_r.rlast   = head_s.last;
  assign ram_r.rid     = head_s.id;

endmodule

// File: tb/tb_ram_rd_slave.sv
// Directed bench for ram_rd_slave: SRAM model, expected-beat and expected-index scoreboards.
module tb_ram_rd_slave;
  import ram_rd_slave_pkg::*;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int unsigned MEM_WORDS = 32768;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [38:0] exp_q[$];
  int unsigned mem_q[$];
  int n_en, n_acc;
  bit prev_stall;
  logic [39:0] prev_out;

  axi_if ram_r();

  ram_rd_slave #(.BASE(BASE), .MEM_WORDS(MEM_WORDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .ram_r     (ram_r),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word_of(input int unsigned idx);
    return 32'hC0DE_0000 + idx;
  endfunction

  // SRAM: data for the strobed index one cycle later, garbage otherwise.
  always @(posedge clock) mem_rdata <= mem_en ? word_of(32'(mem_addr)) : 32'hBAD0_BAD0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beats and SRAM indices for one burst, straight from the address rules.
  task automatic model_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, base_a, step, win;
    bit bad_all, sticky, err, in_rng;
    a = addr;
    sticky = 1'b0;
    step = 32'd1 << size;
    win = (32'(len) + 32'd1) << size;
    bad_all = (size > 3'd2) || (burst == 2'd3) ||
              ((burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    for (int i = 0; i <= int'(len); i++) begin
      in_rng = (a >= BASE) && ({32'h0, a} < ({32'h0, BASE} + 64'(4 * MEM_WORDS)));
      err = bad_all || sticky || !in_rng;
      if (err) sticky = 1'b1;
      else mem_q.push_back((a - BASE) >> 2);
      exp_q.push_back({err ? 32'h0 : word_of((a - BASE) >> 2), err ? 2'b10 : 2'b00,
                       (i == int'(len)) ? 1'b1 : 1'b0, id});
      if (burst == 2'd1) a = a + step;
      else if (burst == 2'd2 && win != 32'd0) begin
        base_a = a - (a % win);
        a = base_a + ((a - base_a + step) % win);
      end
    end
  endtask

  // One cycle: drive at the falling edge, then check what the DUT shows.
  task automatic tick(input bit rr, input bit rst);
    logic [38:0] exp;
    @(negedge clock);
    reset = rst;
    ram_r.rready = rr;
    #1;
    if (prev_stall)
      chk("r_stable", 64'({ram_r.rvalid, ram_r.rdata, ram_r.rresp, ram_r.rlast, ram_r.rid}), 64'(prev_out));
    prev_stall = ram_r.rvalid && !rr && !rst;
    prev_out = {ram_r.rvalid, ram_r.rdata, ram_r.rresp, ram_r.rlast, ram_r.rid};
    if (ram_r.rvalid && rr) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $error("FAIL extra_beat: observed beat %h expected none", prev_out[38:0]);
      end else begin
        exp = exp_q.pop_front();
        chk("beat", 64'(prev_out[38:0]), 64'(exp));
      end
    end
    if (mem_en) begin
      n_en++;
      if (mem_q.size() == 0) begin
        miscompares++;
        $error("FAIL spurious_mem_en: observed mem_addr %h expected no read", mem_addr);
      end else begin
        chk("mem_addr", 64'(mem_addr), 64'(mem_q.pop_front()));
      end
    end
    chk("outstanding_le2", 64'(n_en - n_acc <= 2), 64'd1);
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    @(negedge clock);
    reset = 1'b0;
    ram_r.araddr = addr; ram_r.arid = id; ram_r.arlen = len;
    ram_r.arsize = size; ram_r.arburst = burst;
    ram_r.arvalid = 1'b1;
    ram_r.rready = 1'b1;
    #1;
    chk("arready_idle", 64'(ram_r.arready), 64'd1);
    model_burst(addr, id, len, size, burst);
    n_en = 0; n_acc = 0; prev_stall = 1'b0;
    @(posedge clock);
    #1;
    ram_r.arvalid = 1'b0;
  endtask

  task automatic drain(input bit random_rr, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++)
      tick(random_rr ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
    chk("drain_beats_left", 64'(exp_q.size()), 64'd0);
    chk("drain_reads_left", 64'(mem_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    ram_r.arvalid = 1'b0; ram_r.rready = 1'b0;
    ram_r.araddr = 32'h0; ram_r.arid = 4'h0; ram_r.arlen = 8'h0;
    ram_r.arsize = 3'd0; ram_r.arburst = 2'd0;
    n_en = 0; n_acc = 0; prev_stall = 1'b0; prev_out = 40'h0;
    repeat (3) @(posedge clock);

    // Reset state
    tick(1'b1, 1'b0);
    chk("rst_arready", 64'(ram_r.arready), 64'd1);
    chk("rst_rvalid", 64'(ram_r.rvalid), 64'd0);
    chk("rst_rlast", 64'(ram_r.rlast), 64'd0);
    chk("rst_rdata", 64'(ram_r.rdata), 64'd0);
    chk("rst_rresp", 64'(ram_r.rresp), 64'd0);
    chk("rst_rid", 64'(ram_r.rid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);

    // Single read of word 4
    send_ar(32'h8000_0010, 4'h3, 8'd0, 3'd2, 2'd1);
    tick(1'b1, 1'b0);
    chk("single_mem_en_p1", 64'(mem_en), 64'd1);
    chk("single_rvalid_p1", 64'(ram_r.rvalid), 64'd0);
    tick(1'b1, 1'b0);
    chk("single_rvalid_p2", 64'(ram_r.rvalid), 64'd1);
    chk("single_rlast_p2", 64'(ram_r.rlast), 64'd1);
    chk("single_rdata_p2", 64'(ram_r.rdata), 64'(word_of(4)));
    tick(1'b1, 1'b0);
    chk("single_rvalid_p3", 64'(ram_r.rvalid), 64'd0);
    chk("single_arready_p3", 64'(ram_r.arready), 64'd1);

    // INCR len 3, one beat per cycle
    send_ar(32'h8000_0000, 4'h5, 8'd3, 3'd2, 2'd1);
    tick(1'b1, 1'b0);
    chk("incr_mem_en_p1", 64'(mem_en), 64'd1);
    for (int rel = 2; rel <= 5; rel++) begin
      tick(1'b1, 1'b0);
      chk("incr_rvalid", 64'(ram_r.rvalid), 64'd1);
      chk("incr_rlast", 64'(ram_r.rlast), 64'(rel == 5));
      chk("incr_rdata", 64'(ram_r.rdata), 64'(word_of(rel - 2)));
    end
    tick(1'b1, 1'b0);
    chk("incr_rvalid_end", 64'(ram_r.rvalid), 64'd0);
    chk("incr_arready_end", 64'(ram_r.arready), 64'd1);

    // WRAP len 3 starting at 0xC
    send_ar(32'h8000_000C, 4'h9, 8'd3, 3'd2, 2'd2);
    chk("wrap_idx0", 64'(mem_q[0]), 64'd3);
    chk("wrap_idx1", 64'(mem_q[1]), 64'd0);
    chk("wrap_idx2", 64'(mem_q[2]), 64'd1);
    chk("wrap_idx3", 64'(mem_q[3]), 64'd2);
    drain(1'b0, 20);

    // Backpressure with a competing AR held during the burst
    send_ar(32'h8000_0200, 4'hA, 8'd7, 3'd2, 2'd1);
    ram_r.araddr = 32'h8000_0400; ram_r.arid = 4'hF; ram_r.arlen = 8'd2;
    ram_r.arvalid = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b0);
      chk("busy_arready", 64'(ram_r.arready), 64'd0);
    end
    ram_r.arvalid = 1'b0;
    drain(1'b1, 200);

    // Error bursts
    send_ar(32'h7FFF_FFFC, 4'h1, 8'd1, 3'd2, 2'd1);
    drain(1'b0, 20);
    send_ar(32'h8000_0000, 4'h2, 8'd1, 3'd3, 2'd1);
    drain(1'b0, 20);
    send_ar(32'h8000_0000, 4'h4, 8'd0, 3'd2, 2'd3);
    drain(1'b0, 20);
    send_ar(32'h8000_0000, 4'h6, 8'd2, 3'd2, 2'd2);
    drain(1'b0, 20);
    send_ar(32'h8001_FFFC, 4'h8, 8'd1, 3'd2, 2'd1);
    drain(1'b1, 40);

    // Reset while beat 2 of a len-7 burst is presented
    send_ar(32'h8000_0100, 4'h6, 8'd7, 3'd2, 2'd1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    exp_q.delete();
    mem_q.delete();
    tick(1'b1, 1'b0);
    chk("mrst_rvalid", 64'(ram_r.rvalid), 64'd0);
    chk("mrst_arready", 64'(ram_r.arready), 64'd1);
    chk("mrst_mem_en", 64'(mem_en), 64'd0);
    send_ar(32'h8000_0040, 4'h7, 8'd0, 3'd2, 2'd1);
    drain(1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
